// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: turns UART col/row/char/EOL frames into tile-buffer write commands
module uart_cmd_parser #(
  parameter int         N_COL          = 80,
  parameter int         N_ROW          = 30,
  parameter int         N_COL_WIDTH    = 7,
  parameter int         N_ROW_WIDTH    = 5,
  parameter int         N_CHARS_WIDTH  = 7,
  parameter logic [7:0] EOL_BYTE       = 8'h0A,
  parameter logic [7:0] CLR_BYTE       = 8'h0C,
  parameter int         TIMEOUT_CYCLES = 2500000
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     rx_wr_i,
  input  logic [7:0]               rx_data_i,
  input  logic                     wr_ready_i,
  output logic                     wr_en_o,
  output logic [N_COL_WIDTH-1:0]   col_o,
  output logic [N_ROW_WIDTH-1:0]   row_o,
  output logic [N_CHARS_WIDTH-1:0] char_o,
  output logic                     busy_o,
  output logic                     err_o,
  output logic [7:0]               err_count_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {S_COL, S_ROW, S_CHAR, S_EOL, S_RESYNC, S_CLEAR} state_t;
  state_t                   state_q;
  logic                     rx_q, wr_en_q, busy_q, sweep_q, err_q;
  logic [N_COL_WIDTH-1:0]   col_q, col_lat_q;
  logic [N_ROW_WIDTH-1:0]   row_q, row_lat_q;
  logic [N_CHARS_WIDTH-1:0] char_q;
  logic [7:0]               err_cnt_q;
  logic [CW-1:0]            cnt_q;
  logic                     strobe_d, pending_d, last_cell_d, col_wrap_d;
  logic [6:0]               b7_d;
  assign strobe_d    = rx_wr_i & ~rx_q;
  assign pending_d   = wr_en_q & ~wr_ready_i;
  assign col_wrap_d  = col_q == N_COL_WIDTH'(N_COL - 1);
  assign last_cell_d = col_wrap_d && row_q == N_ROW_WIDTH'(N_ROW - 1);
  assign b7_d        = rx_data_i[6:0];
  assign wr_en_o     = wr_en_q;
  assign col_o       = col_q;
  assign row_o       = row_q;
  assign char_o      = char_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;
  assign err_count_o = err_cnt_q;
  // Frame decoder, clear sweep, write handshake and idle timeout in one state machine
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= S_COL;
      rx_q      <= 1'b0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      sweep_q   <= 1'b0;
      err_q     <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      char_q    <= '0;
      col_lat_q <= '0;
      row_lat_q <= '0;
      cnt_q     <= '0;
    end else begin
      rx_q  <= rx_wr_i;
      err_q <= 1'b0;
      if (wr_en_q && wr_ready_i) wr_en_q <= 1'b0;
      if (state_q == S_CLEAR) begin
        if (!pending_d) begin
          if (!sweep_q) begin
            wr_en_q <= 1'b1;
            sweep_q <= 1'b1;
            col_q   <= '0;
            row_q   <= '0;
            char_q  <= N_CHARS_WIDTH'(7'h20);
          end else if (last_cell_d) begin
            busy_q  <= 1'b0;
            sweep_q <= 1'b0;
            state_q <= S_COL;
          end else begin
            wr_en_q <= 1'b1;
            col_q   <= col_wrap_d ? '0 : col_q + N_COL_WIDTH'(1);
            if (col_wrap_d) row_q <= row_q + N_ROW_WIDTH'(1);
          end
        end
      end else if (strobe_d) begin
        cnt_q <= '0;
        case (state_q)
          S_COL:
            if (rx_data_i == CLR_BYTE) begin
              state_q <= S_CLEAR;
              busy_q  <= 1'b1;
            end else if (rx_data_i != EOL_BYTE) begin
              col_lat_q <= N_COL_WIDTH'(b7_d >= 7'(N_COL) ? b7_d - 7'(N_COL) : b7_d);
              state_q   <= S_ROW;
            end
          S_ROW:
            if (rx_data_i == EOL_BYTE) begin
              err_q   <= 1'b1;
              state_q <= S_COL;
            end else if (rx_data_i[4:0] >= 5'(N_ROW)) begin
              err_q   <= 1'b1;
              state_q <= S_RESYNC;
            end else begin
              row_lat_q <= N_ROW_WIDTH'(rx_data_i[4:0]);
              state_q   <= S_CHAR;
            end
          S_CHAR:
            if (pending_d) begin
              err_q   <= 1'b1;
              state_q <= S_RESYNC;
            end else begin
              wr_en_q <= 1'b1;
              col_q   <= col_lat_q;
              row_q   <= row_lat_q;
              char_q  <= N_CHARS_WIDTH'(rx_data_i[7] ? 7'h3F : b7_d);
              state_q <= S_EOL;
            end
          S_EOL:
            if (rx_data_i == EOL_BYTE) state_q <= S_COL;
            else begin
              err_q   <= 1'b1;
              state_q <= S_RESYNC;
            end
          default:
            if (rx_data_i == EOL_BYTE) state_q <= S_COL;
        endcase
      end else if (state_q != S_COL) begin
        if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          err_q   <= 1'b1;
          state_q <= S_COL;
          cnt_q   <= '0;
        end else cnt_q <= cnt_q + CW'(1);
      end
    end
  end
  // Saturating count of error pulses
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) err_cnt_q <= '0;
    else if (err_q && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
  end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: randomized scoreboard bench with a line-level reference model
module tb_uart_cmd_parser;
  localparam int TO = 64;
  logic       clk = 1'b0, rstn = 1'b1, rx_wr = 1'b0, wr_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       wr_en, busy, err;
  logic [6:0] col, ch;
  logic [4:0] row;
  logic [7:0] err_cnt;
  logic [18:0] exp_q[$];
  int n_chk = 0, n_pass = 0, exp_err = 0, err_seen = 0, acc_cnt = 0, busy_cyc = 0, ready_mode = 0;

  uart_cmd_parser #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rstn_i(rstn), .rx_wr_i(rx_wr), .rx_data_i(rx_data), .wr_ready_i(wr_ready),
    .wr_en_o(wr_en), .col_o(col), .row_o(row), .char_o(ch), .busy_o(busy), .err_o(err),
    .err_count_o(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  function automatic logic [6:0] col_of(input logic [7:0] b);
    return (b[6:0] >= 7'd80) ? b[6:0] - 7'd80 : b[6:0];
  endfunction

  function automatic logic [7:0] rnd_byte();
    logic [7:0] b;
    do b = 8'($urandom); while (b == 8'h0A || b == 8'h0C);
    return b;
  endfunction

  function automatic logic [7:0] rnd_row(input bit bad);
    logic [7:0] b;
    do b = {3'($urandom), bad ? 5'($urandom_range(30, 31)) : 5'($urandom_range(0, 29))};
    while (b == 8'h0A);
    return b;
  endfunction

  // ready pattern: 0 always, 1 toggling, 2 random, 3 held low
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0: wr_ready = 1'b1;
      1: wr_ready = ~wr_ready;
      2: wr_ready = 1'($urandom_range(0, 1));
      default: wr_ready = 1'b0;
    endcase
  end

  // monitor: pops the scoreboard on every accepted write, counts error pulses and busy cycles
  initial forever begin
    @(negedge clk);
    if (busy) busy_cyc++;
    if (err) err_seen++;
    if (wr_en && wr_ready) begin
      acc_cnt++;
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: got col=%0d row=%0d char=0x%0h with nothing expected", col, row, ch);
      end else chk("write", {13'b0, col, row, ch}, {13'b0, exp_q.pop_front()});
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input bit wf);
    int k = 0;
    if (wf) while (wr_en && k < 1000) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (k == 1000) begin
      n_chk++;
      $display("FAIL wait_write_free: wr_en still 1 after 1000 cycles, expected 0");
    end
    rx_data = b;
    rx_wr = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rx_wr = 1'b0;
    repeat (2) @(posedge clk);
    #2;
  endtask

  // one text line (bytes before EOL); the model decides its outcome from the line as a whole
  task automatic send_line(input int n, input logic [39:0] v, input bit wf);
    logic [7:0] b [5];
    for (int i = 0; i < 5; i++) b[i] = v[39-8*i -: 8];
    if (n == 1) exp_err++;
    else if (n >= 2) begin
      if (b[1][4:0] >= 5'd30) exp_err++;
      else begin
        exp_q.push_back({col_of(b[0]), b[1][4:0], b[2][7] ? 7'h3F : b[2][6:0]});
        if (n > 3) exp_err++;
      end
    end
    for (int i = 0; i < n; i++) send_byte(b[i], wf);
    send_byte(8'h0A, wf);
  endtask

  task automatic checkpoint(input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < 10000) begin
      @(posedge clk);
      k++;
    end
    repeat (4) @(posedge clk);
    #2;
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_err_pulses"}, err_seen, exp_err);
    chk({tag, "_err_count"}, {24'b0, err_cnt}, (exp_err > 255) ? 255 : exp_err);
  endtask

  task automatic push_clear();
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 80; c++) exp_q.push_back({7'(c), 5'(r), 7'h20});
  endtask

  initial begin
    int k, base, kind;
    logic [7:0] b0;
    #1 rstn = 1'b0;
    #2;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_err_count", err_cnt, 0);
    chk("rst_col_row_char", {col, row, ch}, 0);
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #2;
    send_line(3, {8'h05, 8'h03, 8'h41, 16'h0}, 1);
    send_line(3, {8'h55, 8'h1D, 8'hC1, 16'h0}, 1);
    checkpoint("basic");
    send_line(4, {8'h02, 8'h1F, 8'h41, 8'h42, 8'h0}, 1);
    send_line(3, {8'h01, 8'h01, 8'h5A, 16'h0}, 1);
    send_line(0, 40'h0, 1);
    checkpoint("bad_row");
    ready_mode = 3;
    repeat (3) @(posedge clk);
    #2;
    exp_q.push_back({7'd1, 5'd2, 7'h41});
    exp_err++;
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h41, 0); send_byte(8'h0A, 0);
    send_byte(8'h03, 0); send_byte(8'h04, 0); send_byte(8'h42, 0); send_byte(8'h0A, 0);
    chk("collision_pending_held", {12'b0, wr_en, col, row, ch}, {12'b0, 1'b1, 7'd1, 5'd2, 7'h41});
    ready_mode = 0;
    checkpoint("collision");
    send_byte(8'h04, 1);
    send_byte(8'h02, 1);
    exp_err++;
    repeat (TO + 40) @(posedge clk);
    checkpoint("timeout");
    send_line(3, {8'h07, 8'h00, 8'h30, 16'h0}, 1);
    checkpoint("after_timeout");
    ready_mode = 2;
    repeat (60) begin
      kind = $urandom_range(0, 4);
      b0 = rnd_byte();
      case (kind)
        0: send_line(0, 40'h0, 1);
        1: send_line(1, {b0, 32'h0}, 1);
        2: send_line($urandom_range(2, 3), {b0, rnd_row(1), rnd_byte(), 16'h0}, 1);
        3: send_line(3, {b0, rnd_row(0), rnd_byte(), 16'h0}, 1);
        default: send_line($urandom_range(4, 5), {b0, rnd_row(0), rnd_byte(), rnd_byte(), rnd_byte()}, 1);
      endcase
    end
    checkpoint("random");
    ready_mode = 1;
    push_clear();
    busy_cyc = 0;
    send_byte(8'h0C, 1);
    chk("clear_busy", busy, 1);
    repeat (200) @(posedge clk);
    #2;
    send_byte(8'h41, 0);
    k = 0;
    while (busy && k < 12000) begin
      @(posedge clk);
      k++;
    end
    #2;
    chk("clear_done", busy, 0);
    chk("clear_cycles_about_4800", (busy_cyc >= 4790 && busy_cyc <= 4810) ? 1 : 0, 1);
    checkpoint("clear");
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #2;
    push_clear();
    base = acc_cnt;
    send_byte(8'h0C, 1);
    k = 0;
    while (acc_cnt < base + 1000 && k < 5000) begin
      @(posedge clk);
      k++;
    end
    #2;
    chk("reset_mid_clear_wr_en", wr_en, 1);
    rstn = 1'b0;
    #1;
    chk("async_rst_wr_en", wr_en, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_col_row_char", {col, row, ch}, 0);
    chk("async_rst_err_count", err_cnt, 0);
    exp_q.delete();
    exp_err = 0;
    err_seen = 0;
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    base = acc_cnt;
    send_line(3, {8'h00, 8'h00, 8'h21, 16'h0}, 1);
    checkpoint("post_reset");
    chk("post_reset_single_write", acc_cnt - base, 1);
    repeat (260) send_line(1, {8'h01, 32'h0}, 1);
    checkpoint("saturate");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
